// File: rtl/n64_bus_arbiter_if.sv
// Requester and memory-controller signals of the N64 bus arbiter.
// The arbiter takes the slave modport; the environment around it takes master.
interface n64_bus_arbiter_if;
  logic [2:0]  i_request;
  logic [2:0]  i_write;
  logic [2:0]  o_busy;
  logic [2:0]  o_ack;
  logic [11:0] i_bank;
  logic [77:0] i_address;
  logic [95:0] i_data;
  logic [31:0] o_data;
  logic        o_mem_request;
  logic        o_mem_write;
  logic        i_mem_busy;
  logic        i_mem_ack;
  logic [3:0]  o_mem_bank;
  logic [25:0] o_mem_address;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;
  logic        o_timeout;

  modport slave (
    input  i_request, i_write, i_bank, i_address, i_data,
    input  i_mem_busy, i_mem_ack, i_mem_data,
    output o_busy, o_ack, o_data, o_timeout,
    output o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data
  );

  modport master (
    output i_request, i_write, i_bank, i_address, i_data,
    output i_mem_busy, i_mem_ack, i_mem_data,
    input  o_busy, o_ack, o_data, o_timeout,
    input  o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data
  );
endinterface

// File: rtl/n64_bus_arbiter.sv
// Shares one memory controller between PI (port 0, priority, burst-limited) and CPU/DMA (ports 1/2,
// round-robin). One transaction in flight; ack and read data return combinationally to the owner.
module n64_bus_arbiter #(
  parameter int unsigned PI_BURST_LIMIT = 8,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input logic              i_clk,
  input logic              i_reset_n,
  n64_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(PI_BURST_LIMIT);
  localparam logic [7:0] TMO_MAX   = 8'(ACK_TIMEOUT);
  localparam bit         TMO_EN    = (ACK_TIMEOUT != 0);

  state_t      state, state_nxt;
  logic [1:0]  owner, owner_nxt;
  logic [3:0]  burst_cnt, burst_nxt;
  logic        rr_port2, rr_nxt;
  logic [7:0]  tmo_cnt, tmo_nxt;
  logic        mem_req, mem_req_nxt;
  logic        mem_wr, mem_wr_nxt;
  logic [3:0]  mem_bank, mem_bank_nxt;
  logic [25:0] mem_addr, mem_addr_nxt;
  logic [31:0] mem_wdata, mem_wdata_nxt;

  logic        others;
  logic        win_vld;
  logic [1:0]  winner;
  logic [3:0]  sel_bank;
  logic [25:0] sel_addr;
  logic [31:0] sel_data;
  logic        sel_wr;
  logic        tmo_fire;

  // PI keeps priority until it has taken BURST_MAX grants in a row while someone else waits.
  always_comb begin
    others  = bus.i_request[1] | bus.i_request[2];
    win_vld = 1'b1;
    winner  = 2'd0;
    if (bus.i_request[0] && !(burst_cnt == BURST_MAX && others)) begin
      winner = 2'd0;
    end else if (bus.i_request[1] && bus.i_request[2]) begin
      winner = rr_port2 ? 2'd2 : 2'd1;
    end else if (bus.i_request[1]) begin
      winner = 2'd1;
    end else if (bus.i_request[2]) begin
      winner = 2'd2;
    end else begin
      win_vld = 1'b0;
    end
  end

  always_comb begin
    sel_bank = bus.i_bank[3:0];
    sel_addr = bus.i_address[25:0];
    sel_data = bus.i_data[31:0];
    sel_wr   = bus.i_write[0];
    case (winner)
      2'd1: begin
        sel_bank = bus.i_bank[7:4];
        sel_addr = bus.i_address[51:26];
        sel_data = bus.i_data[63:32];
        sel_wr   = bus.i_write[1];
      end
      2'd2: begin
        sel_bank = bus.i_bank[11:8];
        sel_addr = bus.i_address[77:52];
        sel_data = bus.i_data[95:64];
        sel_wr   = bus.i_write[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      owner     <= 2'd0;
      burst_cnt <= 4'd0;
      rr_port2  <= 1'b0;
      tmo_cnt   <= 8'd0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_bank  <= 4'd0;
      mem_addr  <= 26'd0;
      mem_wdata <= 32'd0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
      rr_port2  <= rr_nxt;
      tmo_cnt   <= tmo_nxt;
      mem_req   <= mem_req_nxt;
      mem_wr    <= mem_wr_nxt;
      mem_bank  <= mem_bank_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    burst_nxt     = burst_cnt;
    rr_nxt        = rr_port2;
    tmo_nxt       = tmo_cnt;
    mem_req_nxt   = mem_req;
    mem_wr_nxt    = mem_wr;
    mem_bank_nxt  = mem_bank;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    bus.o_busy    = 3'b111;
    bus.o_ack     = 3'b000;
    bus.o_data    = 32'd0;
    bus.o_timeout = 1'b0;
    tmo_fire      = TMO_EN && (tmo_cnt == TMO_MAX);

    case (state)
      IDLE: begin
        if (win_vld) begin
          bus.o_busy    = ~(3'b001 << winner);
          state_nxt     = ISSUE;
          owner_nxt     = winner;
          mem_req_nxt   = 1'b1;
          mem_wr_nxt    = sel_wr;
          mem_bank_nxt  = sel_bank;
          mem_addr_nxt  = sel_addr;
          mem_wdata_nxt = sel_data;
          if (winner == 2'd0) begin
            burst_nxt = others ? burst_cnt + 4'd1 : 4'd0;
          end else begin
            burst_nxt = 4'd0;
            rr_nxt    = (winner == 2'd1);
          end
        end
      end
      ISSUE: begin
        if (!bus.i_mem_busy) begin
          mem_req_nxt = 1'b0;
          mem_wr_nxt  = 1'b0;
          tmo_nxt     = 8'd0;
          state_nxt   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A real ack wins over a timeout landing in the same cycle.
        if (bus.i_mem_ack) begin
          bus.o_ack  = 3'b001 << owner;
          bus.o_data = bus.i_mem_data;
          state_nxt  = IDLE;
        end else if (tmo_fire) begin
          bus.o_ack     = 3'b001 << owner;
          bus.o_data    = 32'hFFFF_FFFF;
          bus.o_timeout = 1'b1;
          state_nxt     = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_mem_request = mem_req;
  assign bus.o_mem_write   = mem_wr;
  assign bus.o_mem_bank    = mem_bank;
  assign bus.o_mem_address = mem_addr;
  assign bus.o_mem_data    = mem_wdata;

endmodule
